// File: rtl/led_scan_ctrl.sv
// Row scan sequencer for a 16x32 RGB panel driven as two 8-row halves.
// Optional PWM dimming within the display window: define LED_SCAN_DIM_EN.
module led_scan_ctrl #(
  parameter int COLS       = 32,
  parameter int ROW_BITS   = 3,
  parameter int DISP_TICKS = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      tick,
  input  logic [2:0]                rgb_top,
  input  logic [2:0]                rgb_bot,
`ifdef LED_SCAN_DIM_EN
  input  logic [$clog2(DISP_TICKS):0] duty,
`endif
  output logic [$clog2(COLS)-1:0]   col_addr,
  output logic [ROW_BITS-1:0]       row_addr,
  output logic [2:0]                LEDs1,
  output logic [2:0]                LEDs2,
  output logic [ROW_BITS-1:0]       rowSelect,
  output logic                      sclk,
  output logic                      latch,
  output logic                      blank,
  output logic                      frame_start,
  output logic [2:0]                o_dbg_state
);

  localparam int CW = $clog2(COLS);
  localparam int DW = $clog2(DISP_TICKS) + 1;

  localparam logic [2:0] S_SHIFT_LO = 3'd0;
  localparam logic [2:0] S_SHIFT_HI = 3'd1;
  localparam logic [2:0] S_BLANK    = 3'd2;
  localparam logic [2:0] S_LATCH    = 3'd3;
  localparam logic [2:0] S_UNBLANK  = 3'd4;
  localparam logic [2:0] S_DISPLAY  = 3'd5;

  localparam logic [CW-1:0] LAST_COL  = CW'(COLS - 1);
  localparam logic [DW-1:0] LAST_DISP = DW'(DISP_TICKS - 1);

  logic [2:0]          r_state;
  logic [CW-1:0]       r_col;
  logic [ROW_BITS-1:0] r_row;
  logic [DW-1:0]       r_disp_cnt;
  logic                r_shown;
  logic                r_sclk;
  logic                r_latch;
  logic                r_blank;
  logic                r_frame;
  logic [ROW_BITS-1:0] r_rowsel;
  logic [2:0]          r_leds1;
  logic [2:0]          r_leds2;
  logic [DW-1:0]       w_disp_next;
`ifdef LED_SCAN_DIM_EN
  logic [DW-1:0]       r_duty;
`endif

  assign w_disp_next = r_disp_cnt + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_SHIFT_LO;
      r_col      <= '0;
      r_row      <= '0;
      r_disp_cnt <= '0;
      r_shown    <= 1'b0;
      r_sclk     <= 1'b0;
      r_latch    <= 1'b0;
      r_blank    <= 1'b1;
      r_frame    <= 1'b0;
      r_rowsel   <= '0;
      r_leds1    <= 3'd0;
      r_leds2    <= 3'd0;
`ifdef LED_SCAN_DIM_EN
      r_duty     <= '0;
`endif
    end else begin
      // frame_start is a single-clk pulse even when ticks are sparse
      r_frame <= 1'b0;
      if (tick) begin
        case (r_state)
          S_SHIFT_LO: begin
            r_leds1 <= rgb_top;
            r_leds2 <= rgb_bot;
            r_sclk  <= 1'b1;
`ifdef LED_SCAN_DIM_EN
            r_blank <= 1'b1;
`else
            r_blank <= ~r_shown;
`endif
            r_state <= S_SHIFT_HI;
          end
          S_SHIFT_HI: begin
            r_sclk <= 1'b0;
            if (r_col != LAST_COL) begin
              r_col   <= r_col + 1'b1;
              r_state <= S_SHIFT_LO;
            end else begin
              r_col   <= '0;
              r_blank <= 1'b1;
              r_state <= S_BLANK;
            end
          end
          S_BLANK: begin
            r_blank <= 1'b1;
            r_state <= S_LATCH;
          end
          S_LATCH: begin
            r_latch  <= 1'b1;
            r_rowsel <= r_row;
            r_blank  <= 1'b1;
            if (r_row == '0) r_frame <= 1'b1;
            r_state  <= S_UNBLANK;
          end
          S_UNBLANK: begin
            r_latch    <= 1'b0;
            r_shown    <= 1'b1;
            r_disp_cnt <= '0;
`ifdef LED_SCAN_DIM_EN
            r_duty     <= duty;
            r_blank    <= (duty == '0);
`else
            r_blank    <= 1'b0;
`endif
            r_state    <= S_DISPLAY;
          end
          S_DISPLAY: begin
            r_disp_cnt <= w_disp_next;
`ifdef LED_SCAN_DIM_EN
            // blank tracks the count after this tick so the panel goes dark at disp_cnt==duty
            r_blank    <= (w_disp_next >= r_duty);
`endif
            if (r_disp_cnt == LAST_DISP) begin
              r_row   <= r_row + 1'b1;
`ifdef LED_SCAN_DIM_EN
              r_blank <= 1'b1;
`endif
              r_state <= S_SHIFT_LO;
            end
          end
          default: r_state <= S_SHIFT_LO;
        endcase
      end
    end
  end

  assign col_addr    = r_col;
  assign row_addr    = r_row;
  assign LEDs1       = r_leds1;
  assign LEDs2       = r_leds2;
  assign rowSelect   = r_rowsel;
  assign sclk        = r_sclk;
  assign latch       = r_latch;
  assign blank       = r_blank;
  assign frame_start = r_frame;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Directed bench for led_scan_ctrl with COLS=4, ROW_BITS=3, DISP_TICKS=2 (13 ticks per row).
// Expected outputs come from a tick-phase model of the row timeline.
module tb_led_scan_ctrl;

  logic       clk;
  logic       reset;
  logic       tick;
  logic [2:0] rgb_top;
  logic [2:0] rgb_bot;
  logic [1:0] col_addr;
  logic [2:0] row_addr;
  logic [2:0] LEDs1;
  logic [2:0] LEDs2;
  logic [2:0] rowSelect;
  logic       sclk;
  logic       latch;
  logic       blank;
  logic       frame_start;
  logic [2:0] dbg_state;
`ifdef LED_SCAN_DIM_EN
  logic [1:0] duty = 2'd2;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [17:0] RST_VEC = 18'h08000;

  led_scan_ctrl #(.COLS(4), .ROW_BITS(3), .DISP_TICKS(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .tick        (tick),
    .rgb_top     (rgb_top),
    .rgb_bot     (rgb_bot),
`ifdef LED_SCAN_DIM_EN
    .duty        (duty),
`endif
    .col_addr    (col_addr),
    .row_addr    (row_addr),
    .LEDs1       (LEDs1),
    .LEDs2       (LEDs2),
    .rowSelect   (rowSelect),
    .sclk        (sclk),
    .latch       (latch),
    .blank       (blank),
    .frame_start (frame_start),
    .o_dbg_state (dbg_state)
  );

  // pixel source: top half shows the column index, bottom half its complement
  assign rgb_top = {1'b0, col_addr};
  assign rgb_bot = ~{1'b0, col_addr};

  logic [17:0] obs;
  assign obs = {sclk, latch, blank, frame_start, rowSelect, row_addr, col_addr, LEDs1, LEDs2};

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // expected outputs after t ticks since reset release
  function automatic logic [17:0] model(input int t);
    int r, p, rm, c;
    logic e_sclk, e_latch, e_blank, e_fs;
    logic [2:0] e_rs, e_ra, e_l1, e_l2;
    logic [1:0] e_ca;
    r  = t / 13;
    p  = t % 13;
    rm = r % 8;
    e_sclk  = (p >= 1) && (p <= 8) && (p % 2 == 1);
    e_ca    = (p < 8) ? 2'(p / 2) : 2'd0;
    e_ra    = 3'(rm);
    e_latch = (p == 10);
    e_fs    = (p == 10) && (rm == 0);
    e_rs    = (p >= 10) ? 3'(rm) : ((r == 0) ? 3'd0 : 3'((r - 1) % 8));
    e_blank = (r == 0) ? (p < 11) : ((p >= 8) && (p <= 10));
    if (p == 0) c = (r == 0) ? -1 : 3;
    else if (p <= 8) c = (p - 1) / 2;
    else c = 3;
    e_l1 = (c < 0) ? 3'd0 : 3'(c);
    e_l2 = (c < 0) ? 3'd0 : 3'(7 - c);
    return {e_sclk, e_latch, e_blank, e_fs, e_rs, e_ra, e_ca, e_l1, e_l2};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    tick  = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (obs !== RST_VEC)
      $display("FAIL reset_hold got=%h exp=%h", obs, RST_VEC);
    else n_pass++;
  endtask

  task automatic test_first_row();
    logic [17:0] e;
    reset = 1'b0;
    e = model(0);
    n_checks++;
    if (obs !== e) $display("FAIL first_row t=0 got=%h exp=%h", obs, e);
    else n_pass++;
    tick = 1'b1;
    for (int t = 1; t <= 12; t++) begin
      @(negedge clk);
      e = model(t);
      n_checks++;
      if (obs !== e) $display("FAIL first_row t=%0d got=%h exp=%h", t, obs, e);
      else n_pass++;
    end
  endtask

  task automatic test_frame();
    logic [17:0] e;
    int fs_first = -1;
    int fs_count = 0;
    int fs_last  = -1;
    for (int t = 13; t <= 115; t++) begin
      @(negedge clk);
      e = model(t);
      n_checks++;
      if (obs !== e) $display("FAIL frame t=%0d got=%h exp=%h", t, obs, e);
      else n_pass++;
      if (frame_start === 1'b1) begin
        fs_count++;
        if (fs_first < 0) fs_first = t;
        fs_last = t;
      end
    end
    n_checks++;
    if (fs_count != 1 || fs_last != 114)
      $display("FAIL frame_period got count=%0d at=%0d exp count=1 at=114 (first=%0d)",
               fs_count, fs_last, fs_first);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    logic [17:0] e;
    tick  = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tick  = 1'b1;
    for (int t = 1; t <= 70; t++) begin
      @(negedge clk);
      e = model(t);
      n_checks++;
      if (obs !== e) $display("FAIL mid_reset_run t=%0d got=%h exp=%h", t, obs, e);
      else n_pass++;
    end
    // row 5, column 2, sclk high: reset must clear outputs without a clock edge
    reset = 1'b1;
    #1;
    n_checks++;
    if (obs !== RST_VEC) $display("FAIL mid_reset_async got=%h exp=%h", obs, RST_VEC);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (obs !== RST_VEC) $display("FAIL mid_reset_hold got=%h exp=%h", obs, RST_VEC);
    else n_pass++;
    reset = 1'b0;
    for (int t = 1; t <= 14; t++) begin
      @(negedge clk);
      e = model(t);
      n_checks++;
      if (obs !== e) $display("FAIL mid_reset_restart t=%0d got=%h exp=%h", t, obs, e);
      else n_pass++;
    end
  endtask

  task automatic test_slow_tick();
    logic [17:0] e;
    int t = 0;
    tick  = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    e = model(0);
    n_checks++;
    if (obs !== e) $display("FAIL slow_tick t=0 got=%h exp=%h", obs, e);
    else n_pass++;
    for (int j = 0; j < 4 * 53; j++) begin
      tick = (j % 4 == 0);
      @(negedge clk);
      if (j % 4 == 0) t++;
      e = model(t);
      if (j % 4 != 0) e[14] = 1'b0;
      n_checks++;
      if (obs !== e) $display("FAIL slow_tick clk=%0d t=%0d got=%h exp=%h", j, t, obs, e);
      else n_pass++;
    end
    tick = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    tick  = 1'b0;
    test_reset();
    test_first_row();
    test_frame();
    test_mid_reset();
    test_slow_tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
